alu_writeback: RTL and testbench
================================

ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
REQ-001 Parameter NUM_REGS, default 8: register-file depth; address width is 3.
REQ-002 Parameter DATA_W, default 8: data width, matching the 8-bit ALU result.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  ALU stage presents a result.
REQ-006 in_ready  output  1  block can accept; transfer when in_valid & in_ready.
REQ-007 in_result  input  8  ALU output C.
REQ-008 in_carry  input  1  ALU carry / NOT-borrow.
REQ-009 in_zero  input  1  ALU zero flag.
REQ-010 in_dest  input  3  destination register index.
REQ-011 in_wr_en  input  1  write in_result to in_dest on commit.
REQ-012 in_flags_en  input  1  update flags on commit.
REQ-013 ext_wr_en  input  1  external (debug/load) register write, highest priority.
REQ-014 ext_wr_addr  input  3  external write index.
REQ-015 ext_wr_data  input  8  external write data.
REQ-016 rd_a_addr, rd_b_addr  input  3 each  read-port indices (feed ALU A/B).
REQ-017 rd_a_data, rd_b_data  output  8 each  combinational read data.
REQ-018 flags_c, flags_z  output  1 each  registered flags.
REQ-019 pending  output  2  queued-entry count, 0..2.

Function
REQ-020 Accepted transactions enter a 2-entry in-order queue; states EMPTY, ONE, FULL.
REQ-021 in_ready SHALL equal (state != FULL); combinationally independent of in_valid.
REQ-022 Each cycle with queue non-empty and ext_wr_en=0, the head commits: register write if wr_en, flags write if flags_en, head pops.
REQ-023 ext_wr_en=1 blocks commit that cycle; the external write always completes; queue holds.
REQ-024 Minimum latency: accepted in cycle N, architectural state visible in cycle N+1 (EMPTY, no ext write).
REQ-025 Push and pop in the same cycle are legal in ONE (stays ONE) and EMPTY-to-ONE entry commits next cycle, never same cycle.
REQ-026 FULL with pop: transitions to ONE, in_ready rises next cycle; no push accepted while FULL.
REQ-027 Entry with wr_en=0 and flags_en=0 still occupies a slot and pops without side effect.
REQ-028 Flags update: flags_c<=carry, flags_z<=zero, both together; never partially.
REQ-029 Read ports return register contents; same-cycle commit is not visible until next cycle (without bypass).
REQ-030 pending SHALL reflect queue state: EMPTY=0, ONE=1, FULL=2.

Reset
REQ-031 rst_n low: all registers 0, flags_c=0, flags_z=0, state EMPTY, pending=0, in_ready=1, immediately and asynchronously.
REQ-032 Queued entries are discarded on reset mid-operation; release is synchronous to clk.

Configuration
REQ-033 Macro WB_BYPASS_EN defined: read data returns the youngest queued entry with wr_en=1 and matching dest, else the register file.
REQ-034 WB_BYPASS_EN undefined: read ports see the register file only; no bypass muxes synthesised.
REQ-035 Bypass never reflects ext_wr_data before its write edge.

Structure
REQ-036 Shared package holds queue state encoding (EMPTY/ONE/FULL) and REG_AW=3 constant alongside the existing ALU operation codes.
REQ-037 One sub-module: wb_queue (2-entry in-order buffer with push/pop/count); register file and flags inline.

Verification
REQ-038 Reset, then push {result=8'h2A,dest=3,wr_en=1,flags_en=1,carry=1,zero=0} -> next cycle r3=8'h2A, flags_c=1, flags_z=0, pending=0.
REQ-039 Hold ext_wr_en=1 for 3 cycles while pushing 3 results -> two accepted, in_ready=0, pending=2; after release commits in order over 2 cycles.
REQ-040 Push dest=5 value 8'h10 then dest=5 value 8'h20 back-to-back -> final r5=8'h20; with WB_BYPASS_EN, rd_a_addr=5 reads 8'h20 while both queued.
REQ-041 Push with wr_en=0, flags_en=1, zero=1 -> no register changes, flags_z=1.
REQ-042 Assert rst_n=0 with pending=2 -> pending=0, in_ready=1, all registers 0 without a clock edge.
REQ-043 ext_wr_en to r7=8'hFF concurrent with queued write to r7=8'h01 -> cycle after: r7=8'hFF, then 8'h01 after commit.

Source files
------------

// File: rtl/alu_writeback_pkg.sv
// Shared definitions for the ALU writeback stage: queue state encoding,
// register address width and the ALU operation codes used upstream.
package alu_writeback_pkg;

    localparam int REG_AW = 3;

    // Encoded so the state value doubles as the queued-entry count
    typedef enum logic [1:0] {
        Q_EMPTY = 2'd0,
        Q_ONE   = 2'd1,
        Q_FULL  = 2'd2
    } q_state_e;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_NOT = 4'd5,
        ALU_SHL = 4'd6,
        ALU_SHR = 4'd7
    } alu_op_e;

    function automatic logic [1:0] q_count(input q_state_e s);
        return s;
    endfunction

endpackage

// File: rtl/alu_writeback_queue.sv
// wb_queue: two-entry in-order buffer with push/pop and an occupancy count.
// Head is the oldest entry; tail only holds data while the queue is full.
module wb_queue
    import alu_writeback_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic             ready,
    output logic [1:0]       count,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data,
    output logic             tail_valid,
    output logic [WIDTH-1:0] tail_data
);

    q_state_e state;
    q_state_e state_next;
    logic     load_head;
    logic     load_tail;
    logic     shift;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= Q_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // A push into an empty queue is never popped in the same cycle, so
    // an accepted entry always commits on the following edge at the earliest
    always_comb begin
        state_next = state;
        load_head  = 1'b0;
        load_tail  = 1'b0;
        shift      = 1'b0;
        case (state)
            Q_EMPTY: begin
                if (push) begin
                    state_next = Q_ONE;
                    load_head  = 1'b1;
                end
            end
            Q_ONE: begin
                if (push && pop) begin
                    load_head = 1'b1;
                end else if (push) begin
                    state_next = Q_FULL;
                    load_tail  = 1'b1;
                end else if (pop) begin
                    state_next = Q_EMPTY;
                end
            end
            Q_FULL: begin
                if (pop) begin
                    state_next = Q_ONE;
                    shift      = 1'b1;
                end
            end
            default: state_next = Q_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_data <= '0;
            tail_data <= '0;
        end else begin
            if (load_head) begin
                head_data <= push_data;
            end else if (shift) begin
                head_data <= tail_data;
            end
            if (load_tail) begin
                tail_data <= push_data;
            end
        end
    end

    assign ready      = (state != Q_FULL);
    assign count      = q_count(state);
    assign head_valid = (state != Q_EMPTY);
    assign tail_valid = (state == Q_FULL);

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback stage: queues ALU results and commits them to the register
// file and flags in order. Define WB_BYPASS_EN to forward queued writes to the read ports.
module alu_writeback
    import alu_writeback_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int DATA_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic              in_carry,
    input  logic              in_zero,
    input  logic [REG_AW-1:0] in_dest,
    input  logic              in_wr_en,
    input  logic              in_flags_en,
    input  logic              ext_wr_en,
    input  logic [REG_AW-1:0] ext_wr_addr,
    input  logic [DATA_W-1:0] ext_wr_data,
    input  logic [REG_AW-1:0] rd_a_addr,
    input  logic [REG_AW-1:0] rd_b_addr,
    output logic [DATA_W-1:0] rd_a_data,
    output logic [DATA_W-1:0] rd_b_data,
    output logic              flags_c,
    output logic              flags_z,
    output logic [1:0]        pending
);

    localparam int ENTRY_W = DATA_W + REG_AW + 4;

    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head_entry;
    logic [ENTRY_W-1:0] tail_entry;
    logic               q_ready;
    logic               head_valid;
    logic               tail_valid;
    logic               push;
    logic               pop;

    logic [DATA_W-1:0]  head_result;
    logic               head_carry;
    logic               head_zero;
    logic [REG_AW-1:0]  head_dest;
    logic               head_wr_en;
    logic               head_flags_en;

    logic [DATA_W-1:0]  regs [NUM_REGS];

    assign push_entry = {in_wr_en, in_flags_en, in_dest, in_carry, in_zero, in_result};
    assign {head_wr_en, head_flags_en, head_dest, head_carry, head_zero, head_result} = head_entry;

    // An external write steals the write port, so the head waits a cycle
    assign push     = in_valid && q_ready;
    assign pop      = head_valid && !ext_wr_en;
    assign in_ready = q_ready;

    wb_queue #(
        .WIDTH(ENTRY_W)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .push_data (push_entry),
        .ready     (q_ready),
        .count     (pending),
        .head_valid(head_valid),
        .head_data (head_entry),
        .tail_valid(tail_valid),
        .tail_data (tail_entry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (ext_wr_en) begin
            regs[ext_wr_addr] <= ext_wr_data;
        end else if (pop && head_wr_en) begin
            regs[head_dest] <= head_result;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_c <= 1'b0;
            flags_z <= 1'b0;
        end else if (pop && head_flags_en) begin
            flags_c <= head_carry;
            flags_z <= head_zero;
        end
    end

`ifdef WB_BYPASS_EN
    logic [DATA_W-1:0] tail_result;
    logic              tail_carry;
    logic              tail_zero;
    logic [REG_AW-1:0] tail_dest;
    logic              tail_wr_en;
    logic              tail_flags_en;
    logic              unused_tail;

    assign {tail_wr_en, tail_flags_en, tail_dest, tail_carry, tail_zero, tail_result} = tail_entry;
    assign unused_tail = ^{tail_flags_en, tail_carry, tail_zero};

    // Tail is younger than head, so its match is applied last and wins
    always_comb begin
        rd_a_data = regs[rd_a_addr];
        rd_b_data = regs[rd_b_addr];
        if (head_valid && head_wr_en && head_dest == rd_a_addr) rd_a_data = head_result;
        if (tail_valid && tail_wr_en && tail_dest == rd_a_addr) rd_a_data = tail_result;
        if (head_valid && head_wr_en && head_dest == rd_b_addr) rd_b_data = head_result;
        if (tail_valid && tail_wr_en && tail_dest == rd_b_addr) rd_b_data = tail_result;
    end
`else
    logic unused_tail;

    assign unused_tail = ^{tail_valid, tail_entry};
    assign rd_a_data   = regs[rd_a_addr];
    assign rd_b_data   = regs[rd_b_addr];
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback: a scoreboard queue of accepted
// entries drives a reference register file, checked every cycle via the read ports.
module tb_alu_writeback;

    typedef struct {
        logic [7:0] result;
        logic       carry;
        logic       zero;
        logic [2:0] dest;
        logic       wr_en;
        logic       flags_en;
    } tb_entry_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_result;
    logic       in_carry;
    logic       in_zero;
    logic [2:0] in_dest;
    logic       in_wr_en;
    logic       in_flags_en;
    logic       ext_wr_en;
    logic [2:0] ext_wr_addr;
    logic [7:0] ext_wr_data;
    logic [2:0] rd_a_addr;
    logic [2:0] rd_b_addr;
    logic [7:0] rd_a_data;
    logic [7:0] rd_b_data;
    logic       flags_c;
    logic       flags_z;
    logic [1:0] pending;

    int checks = 0;
    int errors = 0;

    logic [7:0] mregs [8];
    logic       mc;
    logic       mz;
    tb_entry_t  mq [$];
    logic [7:0] peek;

    always #10 clk = ~clk;

    alu_writeback #(
        .NUM_REGS(8),
        .DATA_W  (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_carry   (in_carry),
        .in_zero    (in_zero),
        .in_dest    (in_dest),
        .in_wr_en   (in_wr_en),
        .in_flags_en(in_flags_en),
        .ext_wr_en  (ext_wr_en),
        .ext_wr_addr(ext_wr_addr),
        .ext_wr_data(ext_wr_data),
        .rd_a_addr  (rd_a_addr),
        .rd_b_addr  (rd_b_addr),
        .rd_a_data  (rd_a_data),
        .rd_b_data  (rd_b_data),
        .flags_c    (flags_c),
        .flags_z    (flags_z),
        .pending    (pending)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    function automatic logic [7:0] expRead(input logic [2:0] addr);
        logic [7:0] v;
        v = mregs[addr];
`ifdef WB_BYPASS_EN
        foreach (mq[i]) begin
            if (mq[i].wr_en && mq[i].dest == addr) v = mq[i].result;
        end
`endif
        return v;
    endfunction

    task automatic clearModel();
        foreach (mregs[i]) mregs[i] = 8'h00;
        mc = 1'b0;
        mz = 1'b0;
        mq.delete();
    endtask

    task automatic checkState();
        checkOutput("pending", 32'(pending), 32'(mq.size()));
        checkOutput("in_ready", 32'(in_ready), 32'(mq.size() < 2));
        checkOutput("flags_c", 32'(flags_c), 32'(mc));
        checkOutput("flags_z", 32'(flags_z), 32'(mz));
        for (int i = 0; i < 4; i++) begin
            rd_a_addr = 3'(i);
            rd_b_addr = 3'(i + 4);
            #1;
            checkOutput($sformatf("rd_a r%0d", i), 32'(rd_a_data), 32'(expRead(3'(i))));
            checkOutput($sformatf("rd_b r%0d", i + 4), 32'(rd_b_data), 32'(expRead(3'(i + 4))));
        end
    endtask

    task automatic peekReg(input logic [2:0] addr, output logic [7:0] data);
        rd_a_addr = addr;
        #1;
        data = rd_a_data;
    endtask

    // Scoreboard step: the head commits unless an external write is active,
    // then any accepted entry joins the tail
    task automatic stepCycle();
        tb_entry_t  e;
        bit         accept;
        bit         commit;
        bit         xe;
        logic [2:0] xa;
        logic [7:0] xd;
        accept = in_valid && (mq.size() < 2);
        commit = (mq.size() != 0) && !ext_wr_en;
        e = '{result: in_result, carry: in_carry, zero: in_zero,
              dest: in_dest, wr_en: in_wr_en, flags_en: in_flags_en};
        xe = ext_wr_en;
        xa = ext_wr_addr;
        xd = ext_wr_data;
        @(posedge clk);
        if (xe) begin
            mregs[xa] = xd;
        end else if (commit) begin
            tb_entry_t h;
            h = mq.pop_front();
            if (h.wr_en) mregs[h.dest] = h.result;
            if (h.flags_en) begin
                mc = h.carry;
                mz = h.zero;
            end
        end
        if (accept) mq.push_back(e);
        #1;
        checkState();
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] res, input logic c, input logic z,
                                 input logic [2:0] d, input logic we, input logic fe,
                                 input logic xe, input logic [2:0] xa, input logic [7:0] xd);
        in_valid    = v;
        in_result   = res;
        in_carry    = c;
        in_zero     = z;
        in_dest     = d;
        in_wr_en    = we;
        in_flags_en = fe;
        ext_wr_en   = xe;
        ext_wr_addr = xa;
        ext_wr_data = xd;
        stepCycle();
    endtask

    task automatic idle();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_result = 8'h00; in_carry = 1'b0; in_zero = 1'b0;
        in_dest = 3'd0; in_wr_en = 1'b0; in_flags_en = 1'b0;
        ext_wr_en = 1'b0; ext_wr_addr = 3'd0; ext_wr_data = 8'h00;
        rd_a_addr = 3'd0; rd_b_addr = 3'd0;
        clearModel();
        #1;
        checkState();
        @(negedge clk);
        rst_n = 1'b1;

        // Single result: visible one cycle after acceptance completes
        applyStimulus(1'b1, 8'h2A, 1'b1, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00);
        idle();
        peekReg(3'd3, peek);
        checkOutput("r3 after commit", 32'(peek), 32'h2A);
        checkOutput("single flags_c", 32'(flags_c), 32'd1);
        checkOutput("single pending", 32'(pending), 32'd0);

        // External write holds the queue; the third push is refused
        applyStimulus(1'b1, 8'h11, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b1, 3'd0, 8'h55);
        applyStimulus(1'b1, 8'h22, 1'b1, 1'b0, 3'd2, 1'b1, 1'b1, 1'b1, 3'd0, 8'h55);
        applyStimulus(1'b1, 8'h44, 1'b0, 1'b1, 3'd4, 1'b1, 1'b1, 1'b1, 3'd0, 8'h55);
        checkOutput("hold pending", 32'(pending), 32'd2);
        checkOutput("hold in_ready", 32'(in_ready), 32'd0);
        idle();
        checkOutput("drain one pending", 32'(pending), 32'd1);
        idle();
        peekReg(3'd2, peek);
        checkOutput("r2 after drain", 32'(peek), 32'h22);
        peekReg(3'd4, peek);
        checkOutput("r4 refused push", 32'(peek), 32'h00);

        // Two queued writes to r5, held so both are in flight together
        applyStimulus(1'b1, 8'h10, 1'b0, 1'b0, 3'd5, 1'b1, 1'b0, 1'b1, 3'd6, 8'h66);
        applyStimulus(1'b1, 8'h20, 1'b0, 1'b0, 3'd5, 1'b1, 1'b0, 1'b1, 3'd6, 8'h66);
        peekReg(3'd5, peek);
`ifdef WB_BYPASS_EN
        checkOutput("r5 bypass youngest", 32'(peek), 32'h20);
`else
        checkOutput("r5 no bypass", 32'(peek), 32'h00);
`endif
        idle();
        idle();
        applyStimulus(1'b1, 8'h10, 1'b0, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
        applyStimulus(1'b1, 8'h20, 1'b0, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
        idle();
        peekReg(3'd5, peek);
        checkOutput("r5 back-to-back", 32'(peek), 32'h20);

        // Flags-only entry
        applyStimulus(1'b1, 8'hEE, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00);
        idle();
        checkOutput("flags-only z", 32'(flags_z), 32'd1);
        checkOutput("flags-only c", 32'(flags_c), 32'd0);

        // External write lands ahead of an older queued write to the same register
        applyStimulus(1'b1, 8'h01, 1'b0, 1'b0, 3'd7, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd7, 8'hFF);
        peekReg(3'd7, peek);
`ifdef WB_BYPASS_EN
        checkOutput("r7 during hold", 32'(peek), 32'h01);
`else
        checkOutput("r7 during hold", 32'(peek), 32'hFF);
`endif
        idle();
        peekReg(3'd7, peek);
        checkOutput("r7 after commit", 32'(peek), 32'h01);

        for (int n = 0; n < 300; n++) begin
            applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                          1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 4) == 0), 3'($urandom_range(0, 7)), 8'($urandom));
        end

        // Fill the queue, then reset mid-cycle with no clock edge
        applyStimulus(1'b1, 8'h77, 1'b1, 1'b1, 3'd3, 1'b1, 1'b1, 1'b1, 3'd2, 8'h99);
        applyStimulus(1'b1, 8'h88, 1'b1, 1'b1, 3'd4, 1'b1, 1'b1, 1'b1, 3'd2, 8'h99);
        checkOutput("pre-reset pending", 32'(pending), 32'd2);
        rst_n = 1'b0;
        clearModel();
        #1;
        checkOutput("async reset pending", 32'(pending), 32'd0);
        checkOutput("async reset in_ready", 32'(in_ready), 32'd1);
        checkOutput("async reset flags_c", 32'(flags_c), 32'd0);
        for (int i = 0; i < 4; i++) begin
            rd_a_addr = 3'(i);
            rd_b_addr = 3'(i + 4);
            #1;
            checkOutput($sformatf("async reset r%0d", i), 32'(rd_a_data), 32'h00);
            checkOutput($sformatf("async reset r%0d", i + 4), 32'(rd_b_data), 32'h00);
        end
        in_valid = 1'b0;
        ext_wr_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0, 3'd6, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
